fft_core: RTL and testbench
===========================

Name: fft_core

Overview:
- 32-point complex radix-2 FFT engine with streaming serial input and streaming serial output.
- Accepts one 12-bit complex sample per cycle while in_valid is high, collects a 32-sample frame, and computes the forward DFT.
- Emits 32 16-bit complex bins in natural order (bin 0 first), one per cycle, under out_valid.
- Sits upstream of a 32-word serial-in/parallel-out capture register that shifts dout_r/dout_i while out_valid is high.

Parameters:
- FFT_SIZE, 32, points per frame (fixed; the only supported value)
- IN_WIDTH, 12, signed input width per component
- OUT_WIDTH, 16, signed output width per component
- TW_WIDTH, 16, signed twiddle width, Q2.14 format (1.0 = 16384)
- OUT_LATENCY, 48, clock cycles from capture of sample 31 to first out_valid cycle

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  din_r/din_i hold a valid sample this cycle
- din_r  in  12  signed real part of input sample
- din_i  in  12  signed imaginary part of input sample
- out_valid  out  1  high for exactly 32 consecutive cycles while bins are presented
- dout_r  out  16  signed real part of current bin
- dout_i  out  16  signed imaginary part of current bin
- done  out  1  one-cycle pulse on the cycle after the last bin (bin 31)

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid, done, dout_r, dout_i go to 0.
  - State returns to LOAD and the sample counter clears.
  - Buffer contents are don't-care.
  - Reset mid-frame, mid-compute or mid-output aborts the frame; nothing further is emitted.
- States: LOAD -> COMPUTE -> OUTPUT -> LOAD.
- LOAD:
  - On each rising edge with in_valid=1, store {din_r, din_i} as sample n (n = 0..31 in arrival order) and increment n.
  - Cycles with in_valid=0 are gaps and store nothing.
  - Capturing sample 31 moves the block to COMPUTE.
- COMPUTE:
  - Computes X[k] = sum over n of x[n]·exp(-j2πnk/32), k = 0..31.
  - Architecture is free: in-place radix-2 DIT/DIF with bit-reverse addressing or a pipelined SDF, provided timing is met.
  - in_valid is ignored; samples arriving here are dropped, not queued.
- OUTPUT:
  - The first out_valid cycle begins exactly OUT_LATENCY (48) cycles after the edge that captured sample 31. This is ≤ 68 cycles after in_valid falls.
  - out_valid stays high for exactly 32 consecutive cycles, presenting bin k on cycle k (k = 0..31), registered outputs.
  - After bin 31: out_valid=0, dout_r/dout_i return to 0, done=1 for one cycle, state returns to LOAD.
  - in_valid is ignored during OUTPUT.
  - A new frame may start on the cycle done is high.
- Arithmetic:
  - Internal datapath grows 1 bit per stage: 12 -> 17 bits plus ≥2 fractional guard bits.
  - Twiddles are rounded cos/sin constants in Q2.14 (ROM or case table, 16 entries for W32^0..15).
  - Product rounding: round-half-up at each stage.
  - Output is unscaled X[k] rounded to integer, then saturated to [-32768, 32767].
- Accuracy:
  - Trivial-twiddle results (DC, impulse at n=0, alternating ±A) are bit-exact.
  - General inputs are within ±4 LSB per component of the double-precision DFT.
- dout_r/dout_i are 0 whenever out_valid=0.

Test Plan:
- Impulse: x[0] = 100+0j, others 0, contiguous in_valid -> all 32 bins = 100 + 0i; out_valid is a single 32-cycle pulse starting 48 cycles after the last input; done pulses once afterwards.
- DC: all x[n] = 100+0j -> bin 0 = 3200 + 0i, bins 1..31 = 0 + 0i exactly.
- Single tone: x[n] = round(1000·cos(2πn/32)) + j·round(1000·sin(2πn/32)) -> bin 1 ≈ 32000 + 0i (±4); all other bins within ±4 of 0.
- Full-scale saturation: all x[n] = 2047 + (-2048)j -> bin 0 = 32767 + (-32768)i; other bins 0.
- Gapped input: same impulse frame with in_valid dropped for 3 cycles after samples 5 and 20 -> identical output to the impulse case; latency measured from sample 31.
- Reset mid-OUTPUT: assert rst_n low at bin 10 -> out_valid, dout_r, dout_i, done go to 0 immediately; a following DC frame produces the correct DC result.

Source files
------------

// File: rtl/fft_core.sv
// 32-point radix-2 DIT FFT. Samples load serially into bit-reversed slots, one
// full butterfly stage runs per cycle, and bins are read out in natural order.

module fft_bfly #(
  parameter int DW = 22,
  parameter int TW = 16
) (
  input  logic [DW-1:0] a_r,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_r,
  input  logic [DW-1:0] b_i,
  input  logic [TW-1:0] w_r,
  input  logic [TW-1:0] w_i,
  output logic [DW-1:0] x_r,
  output logic [DW-1:0] x_i,
  output logic [DW-1:0] y_r,
  output logic [DW-1:0] y_i
);
  localparam int PW = DW + TW + 1;

  logic signed [PW-1:0] p_r, p_i;
  logic signed [DW-1:0] t_r, t_i;

  always_comb begin
    p_r = PW'($signed(b_r)) * PW'($signed(w_r)) - PW'($signed(b_i)) * PW'($signed(w_i));
    p_i = PW'($signed(b_r)) * PW'($signed(w_i)) + PW'($signed(b_i)) * PW'($signed(w_r));
    // Q2.14 twiddle: drop 14 fraction bits with round-half-up
    t_r = DW'((p_r + PW'(8192)) >>> 14);
    t_i = DW'((p_i + PW'(8192)) >>> 14);
    x_r = a_r + t_r;
    x_i = a_i + t_i;
    y_r = a_r - t_r;
    y_i = a_i - t_i;
  end
endmodule

module fft_core #(
  parameter int FFT_SIZE    = 32,
  parameter int IN_WIDTH    = 12,
  parameter int OUT_WIDTH   = 16,
  parameter int TW_WIDTH    = 16,
  parameter int OUT_LATENCY = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  din_r,
  input  logic [IN_WIDTH-1:0]  din_i,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] dout_r,
  output logic [OUT_WIDTH-1:0] dout_i,
  output logic                 done
);
  localparam int N     = FFT_SIZE;
  localparam int HALF  = N / 2;
  localparam int GUARD = 2;
  // 5 bits of growth, 2 guard fraction bits, 3 bits headroom for rotation
  localparam int DW    = IN_WIDTH + 5 + GUARD + 3;
  localparam logic signed [DW-1:0] SAT_HI = DW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [DW-1:0] SAT_LO = DW'(-(2 ** (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t                     state_q, state_d;
  logic [5:0]                 cnt_q, cnt_d;
  logic [N-1:0][DW-1:0]       mem_r_q, mem_r_d, mem_i_q, mem_i_d;
  logic                       out_valid_q, out_valid_d, done_q, done_d;
  logic [OUT_WIDTH-1:0]       dout_r_q, dout_r_d, dout_i_q, dout_i_d;
  logic [HALF-1:0][4:0]       top_idx, bot_idx;
  logic [HALF-1:0][TW_WIDTH-1:0] tw_r, tw_i;
  logic [HALF-1:0][DW-1:0]    bx_r, bx_i, by_r, by_i;
  logic [2:0]                 stg;
  logic [4:0]                 lo_mask, bidx;
  logic [3:0]                 widx;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  // cos(2*pi*i/32) in Q2.14 for i = 0..8; sin and the upper half fold onto it
  function automatic logic [TW_WIDTH-1:0] tw_base(input logic [3:0] i);
    case (i)
      4'd0:    return TW_WIDTH'(16384);
      4'd1:    return TW_WIDTH'(16069);
      4'd2:    return TW_WIDTH'(15137);
      4'd3:    return TW_WIDTH'(13623);
      4'd4:    return TW_WIDTH'(11585);
      4'd5:    return TW_WIDTH'(9102);
      4'd6:    return TW_WIDTH'(6270);
      4'd7:    return TW_WIDTH'(3196);
      default: return '0;
    endcase
  endfunction

  function automatic logic [OUT_WIDTH-1:0] round_sat(input logic [DW-1:0] v);
    logic signed [DW-1:0] r;
    r = ($signed(v) + DW'(2)) >>> GUARD;
    if (r > SAT_HI)      r = SAT_HI;
    else if (r < SAT_LO) r = SAT_LO;
    return r[OUT_WIDTH-1:0];
  endfunction

  // Stage s pairs slots p apart by 2^s and uses twiddle W32^(p << (4-s))
  always_comb begin
    stg     = cnt_q[2:0];
    lo_mask = 5'((6'd1 << stg) - 6'd1);
    bidx    = '0;
    widx    = '0;
    top_idx = '0;
    bot_idx = '0;
    tw_r    = '0;
    tw_i    = '0;
    for (int b = 0; b < HALF; b++) begin
      bidx       = 5'(b);
      top_idx[b] = 5'((bidx & ~lo_mask) << 1) | (bidx & lo_mask);
      bot_idx[b] = top_idx[b] | 5'(lo_mask + 5'd1);
      widx       = 4'((bidx & lo_mask) << (3'd4 - stg));
      if (widx <= 4'd8) begin
        tw_r[b] = tw_base(widx);
        tw_i[b] = -tw_base(4'(4'd8 - widx));
      end else begin
        tw_r[b] = -tw_base(4'(5'd16 - {1'b0, widx}));
        tw_i[b] = -tw_base(4'(widx - 4'd8));
      end
    end
  end

  for (genvar g = 0; g < HALF; g++) begin : g_bfly
    fft_bfly #(.DW(DW), .TW(TW_WIDTH)) u_bfly (
      .a_r (mem_r_q[top_idx[g]]),
      .a_i (mem_i_q[top_idx[g]]),
      .b_r (mem_r_q[bot_idx[g]]),
      .b_i (mem_i_q[bot_idx[g]]),
      .w_r (tw_r[g]),
      .w_i (tw_i[g]),
      .x_r (bx_r[g]),
      .x_i (bx_i[g]),
      .y_r (by_r[g]),
      .y_i (by_i[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_r_d     = mem_r_q;
    mem_i_d     = mem_i_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    dout_r_d    = '0;
    dout_i_d    = '0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          mem_r_d[bitrev5(cnt_q[4:0])] = {{(DW-IN_WIDTH-GUARD){din_r[IN_WIDTH-1]}}, din_r, {GUARD{1'b0}}};
          mem_i_d[bitrev5(cnt_q[4:0])] = {{(DW-IN_WIDTH-GUARD){din_i[IN_WIDTH-1]}}, din_i, {GUARD{1'b0}}};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(N - 1)) begin
            state_d = COMPUTE;
            cnt_d   = '0;
          end
        end
      end
      COMPUTE: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q < 6'd5) begin
          for (int b = 0; b < HALF; b++) begin
            mem_r_d[top_idx[b]] = bx_r[b];
            mem_i_d[top_idx[b]] = bx_i[b];
            mem_r_d[bot_idx[b]] = by_r[b];
            mem_i_d[bot_idx[b]] = by_i[b];
          end
        end
        // Idle after the last stage so bin 0 lands at a fixed latency
        if (cnt_q == 6'(OUT_LATENCY - 1)) begin
          state_d     = OUTPUT;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          dout_r_d    = round_sat(mem_r_q[0]);
          dout_i_d    = round_sat(mem_i_q[0]);
        end
      end
      OUTPUT: begin
        if (cnt_q == 6'(N - 1)) begin
          state_d = LOAD;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d       = cnt_q + 6'd1;
          out_valid_d = 1'b1;
          dout_r_d    = round_sat(mem_r_q[5'(cnt_q[4:0] + 5'd1)]);
          dout_i_d    = round_sat(mem_i_q[5'(cnt_q[4:0] + 5'd1)]);
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_r_q <= mem_r_d;
    mem_i_q <= mem_i_d;
  end

  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;
endmodule

// File: tb/tb_fft_core.sv
// Bench for fft_core: frames are checked against a double-precision DFT of the
// same samples, with bin timing, done pulse and idle-zero outputs checked every cycle.

module tb_fft_core;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [11:0] din_r = '0, din_i = '0;
  logic        out_valid, done;
  logic [15:0] dout_r, dout_i;

  int cyc = 0, checks = 0, failures = 0;
  int fr_r[32], fr_i[32], m_r[32], m_i[32], exp_r[32], exp_i[32];
  int exp_start = -1, exp_tol = 0;

  fft_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int rnd_sat(input real v);
    real f;
    f = $floor(v + 0.5);
    if (f > 32767.0) return 32767;
    if (f < -32768.0) return -32768;
    return $rtoi(f);
  endfunction

  // Reference: direct DFT X[k] = sum x[n] * exp(-j*2*pi*n*k/32)
  task automatic model();
    real sr, si, th;
    for (int k = 0; k < 32; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 32; n++) begin
        th = 2.0 * PI * real'(n * k) / 32.0;
        sr += fr_r[n] * $cos(th) + fr_i[n] * $sin(th);
        si += fr_i[n] * $cos(th) - fr_r[n] * $sin(th);
      end
      m_r[k] = rnd_sat(sr);
      m_i[k] = rnd_sat(si);
    end
  endtask

  always @(negedge clk) begin
    int k;
    if (!rst_n) begin
      exp_start = -1;
      chk(!out_valid && !done && dout_r == 16'd0 && dout_i == 16'd0, "reset_outputs_zero",
          int'(out_valid) + int'(done) + int'(dout_r != 16'd0), 0);
    end else begin
      k = (exp_start >= 0) ? cyc - exp_start : -1;
      chk(out_valid == (k >= 0 && k < 32), "out_valid", int'(out_valid), int'(k >= 0 && k < 32));
      chk(done == (k == 32), "done", int'(done), int'(k == 32));
      if (out_valid && k >= 0 && k < 32) begin
        chk(iabs(int'($signed(dout_r)) - exp_r[k]) <= exp_tol, $sformatf("bin%0d_re", k),
            int'($signed(dout_r)), exp_r[k]);
        chk(iabs(int'($signed(dout_i)) - exp_i[k]) <= exp_tol, $sformatf("bin%0d_im", k),
            int'($signed(dout_i)), exp_i[k]);
      end else begin
        chk(dout_r == 16'd0 && dout_i == 16'd0, "dout_idle_zero",
            int'($signed(dout_r)), 0);
      end
      if (k >= 32) exp_start = -1;
    end
  end

  // gap_mode: 0 contiguous, 1 three-cycle gaps after samples 5 and 20, 2 random gaps.
  // noise drives junk in_valid while the frame is processed; rst_bin >= 0 resets at that bin.
  task automatic send_frame(input int gap_mode, input int tol, input bit noise, input int rst_bin);
    int cap, gaps;
    for (int n = 0; n < 32; n++) begin
      gaps = (gap_mode == 1 && (n == 6 || n == 21)) ? 3 :
             (gap_mode == 2 && $urandom_range(0, 3) == 0) ? 1 : 0;
      for (int g = 0; g < gaps; g++) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        din_r = 12'($urandom);
        din_i = 12'($urandom);
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      din_r = 12'(fr_r[n]);
      din_i = 12'(fr_i[n]);
    end
    cap = cyc + 1;
    exp_r = m_r;
    exp_i = m_i;
    exp_tol = tol;
    exp_start = cap + 48;
    for (int j = 0; j < 80; j++) begin
      @(posedge clk); #1;
      if (rst_bin >= 0 && j == 48 + rst_bin) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      din_r = 12'($urandom);
      din_i = 12'($urandom);
    end
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int n = 0; n < 32; n++) begin fr_r[n] = (n == 0) ? 100 : 0; fr_i[n] = 0; end
    model();
    chk(m_r[17] == 100 && m_i[9] == 0, "model_impulse", m_r[17], 100);
    send_frame(0, 0, 1'b0, -1);

    for (int n = 0; n < 32; n++) begin fr_r[n] = 100; fr_i[n] = 0; end
    model();
    chk(m_r[0] == 3200 && m_i[0] == 0, "model_dc_bin0", m_r[0], 3200);
    chk(m_r[5] == 0 && m_i[5] == 0, "model_dc_bin5", m_r[5], 0);
    send_frame(0, 0, 1'b1, -1);

    for (int n = 0; n < 32; n++) begin
      fr_r[n] = $rtoi($floor(1000.0 * $cos(2.0 * PI * n / 32.0) + 0.5));
      fr_i[n] = $rtoi($floor(1000.0 * $sin(2.0 * PI * n / 32.0) + 0.5));
    end
    model();
    chk(iabs(m_r[1] - 32000) <= 4, "model_tone_bin1", m_r[1], 32000);
    send_frame(0, 4, 1'b1, -1);

    for (int n = 0; n < 32; n++) begin fr_r[n] = 2047; fr_i[n] = -2048; end
    model();
    chk(m_r[0] == 32767 && m_i[0] == -32768, "model_sat_bin0", m_i[0], -32768);
    send_frame(0, 0, 1'b0, -1);

    for (int n = 0; n < 32; n++) begin fr_r[n] = (n == 0) ? 100 : 0; fr_i[n] = 0; end
    model();
    send_frame(1, 0, 1'b0, -1);

    for (int n = 0; n < 32; n++) begin fr_r[n] = (n % 2 == 0) ? 300 : -300; fr_i[n] = 0; end
    model();
    chk(m_r[16] == 9600 && m_r[0] == 0, "model_alt_bin16", m_r[16], 9600);
    send_frame(0, 0, 1'b1, -1);

    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 32; n++) begin
        fr_r[n] = int'($urandom_range(0, 2000)) - 1000;
        fr_i[n] = int'($urandom_range(0, 2000)) - 1000;
      end
      model();
      send_frame(2, 4, 1'b1, -1);
    end

    for (int n = 0; n < 32; n++) begin fr_r[n] = (n == 0) ? 100 : 0; fr_i[n] = 0; end
    model();
    send_frame(0, 0, 1'b0, 10);

    for (int n = 0; n < 32; n++) begin fr_r[n] = 100; fr_i[n] = 0; end
    model();
    send_frame(0, 0, 1'b0, -1);

    @(posedge clk); #1 in_valid = 1'b0;
    for (int t = 0; t < 200 && exp_start >= 0; t++) @(posedge clk);
    chk(exp_start < 0, "final_frame_timeout", exp_start, -1);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
